// File: rtl/attn_pkg.sv
// Shared types and fixed-point helpers for the attention context engine.
package attn_pkg;

  localparam int unsigned FxWidth = 32;
  localparam int unsigned FxFrac  = 14;

  localparam logic signed [FxWidth-1:0] ONE_FX = FxWidth'(1) << FxFrac;

  typedef enum logic [1:0] {
    StIdle,
    StScore,
    StAccum,
    StDone
  } state_t;

  // Full-width signed product, arithmetic shift back to Q-format, then truncate.
  function automatic logic signed [FxWidth-1:0] fx_mul(input logic signed [FxWidth-1:0] a,
                                                       input logic signed [FxWidth-1:0] b);
    logic signed [2*FxWidth-1:0] prod;
    prod = (2*FxWidth)'(a) * (2*FxWidth)'(b);
    prod = prod >>> FxFrac;
    return prod[FxWidth-1:0];
  endfunction

endpackage

// File: rtl/attn_context_mac.sv
// Single shared multiply-shift-accumulate; sum_o is the value the accumulator takes when enabled.
module fx_mac
  import attn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      flush_i,
  input  logic signed [FxWidth-1:0] a_i,
  input  logic signed [FxWidth-1:0] b_i,
  output logic signed [FxWidth-1:0] sum_o
);

  logic signed [FxWidth-1:0] acc_q;

  // clr_i restarts the running sum with this cycle's product as the first term.
  assign sum_o = (clr_i ? '0 : acc_q) + fx_mul(a_i, b_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (flush_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/attn_context.sv
// Linear attention consumer: KV buffer, Q·K scores, then score-weighted sum of V via one MAC.
module attn_context
  import attn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FxWidth,
  parameter int unsigned EMBED_DIM   = 64,
  parameter int unsigned FRAC_BITS   = FxFrac,
  parameter int unsigned SEQ_LEN     = 8,
  parameter int unsigned SCORE_SHIFT = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            kv_wr,
  input  logic                            kv_clear,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0] K_flat,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0] V_flat,
  input  logic                            start,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0] Q_flat,
  output logic [$clog2(SEQ_LEN+1)-1:0]    kv_count,
  output logic                            kv_full,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH*EMBED_DIM-1:0] ctx_flat
);

  localparam int unsigned CntW = $clog2(SEQ_LEN + 1);
  localparam int unsigned TW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned EW   = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam logic [EW-1:0] LastElem = EW'(EMBED_DIM - 1);

  typedef logic signed [DATA_WIDTH-1:0] word_t;

  state_t state_q, state_d;
  logic [CntW-1:0] kv_count_q, kv_count_d, n_q, n_d;
  logic [TW-1:0] t_q, t_d;
  logic [EW-1:0] j_q, j_d, i_q, i_d;
  logic done_q, done_d;
  logic [DATA_WIDTH*EMBED_DIM-1:0] ctx_q;

  word_t k_mem [SEQ_LEN][EMBED_DIM];
  word_t v_mem [SEQ_LEN][EMBED_DIM];
  word_t q_q [EMBED_DIM];
  word_t ctx_w [EMBED_DIM];
  word_t score_q [SEQ_LEN];

  logic  idle, last_t, kv_we, q_we, score_we, ctx_we;
  logic  mac_en, mac_clr, mac_flush;
  word_t mac_a, mac_b, mac_sum;

  assign idle    = (state_q == StIdle);
  assign kv_full = (kv_count_q == CntW'(SEQ_LEN));
  assign kv_we   = idle && kv_wr && !kv_clear && !kv_full;
  assign last_t  = (CntW'(t_q) == n_q - CntW'(1));

  always_comb begin
    kv_count_d = kv_count_q;
    if (idle && kv_clear) begin
      kv_count_d = '0;
    end else if (kv_we) begin
      kv_count_d = kv_count_q + CntW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    t_d       = t_q;
    j_d       = j_q;
    i_d       = i_q;
    done_d    = 1'b0;
    q_we      = 1'b0;
    score_we  = 1'b0;
    ctx_we    = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_flush = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_we      = 1'b1;
          mac_flush = 1'b1;
          // n is sampled before any same-cycle write lands.
          n_d       = kv_count_q;
          t_d       = '0;
          j_d       = '0;
          i_d       = '0;
          state_d   = (kv_count_q != '0) ? StScore : StDone;
        end
      end
      StScore: begin
        mac_en  = 1'b1;
        mac_clr = (j_q == '0);
        mac_a   = q_q[j_q];
        mac_b   = k_mem[t_q][j_q];
        if (j_q == LastElem) begin
          score_we = 1'b1;
          j_d      = '0;
          if (last_t) begin
            t_d     = '0;
            state_d = StAccum;
          end else begin
            t_d = t_q + TW'(1);
          end
        end else begin
          j_d = j_q + EW'(1);
        end
      end
      StAccum: begin
        mac_en  = 1'b1;
        mac_clr = (t_q == '0);
        mac_a   = score_q[t_q];
        mac_b   = v_mem[t_q][i_q];
        if (last_t) begin
          ctx_we = 1'b1;
          t_d    = '0;
          if (i_q == LastElem) begin
            state_d = StDone;
          end else begin
            i_d = i_q + EW'(1);
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  fx_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (mac_en),
    .clr_i   (mac_clr),
    .flush_i (mac_flush),
    .a_i     (mac_a),
    .b_i     (mac_b),
    .sum_o   (mac_sum)
  );

  // Storage with don't-care reset contents.
  always_ff @(posedge clk) begin
    if (kv_we) begin
      for (int unsigned e = 0; e < EMBED_DIM; e++) begin
        k_mem[kv_count_q[TW-1:0]][e] <= K_flat[e*DATA_WIDTH +: DATA_WIDTH];
        v_mem[kv_count_q[TW-1:0]][e] <= V_flat[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (q_we) begin
      for (int unsigned e = 0; e < EMBED_DIM; e++) begin
        q_q[e] <= Q_flat[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (ctx_we) begin
      ctx_w[i_q] <= mac_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      kv_count_q <= '0;
      n_q        <= '0;
      t_q        <= '0;
      j_q        <= '0;
      i_q        <= '0;
      done_q     <= 1'b0;
      ctx_q      <= '0;
      for (int unsigned s = 0; s < SEQ_LEN; s++) begin
        score_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      kv_count_q <= kv_count_d;
      n_q        <= n_d;
      t_q        <= t_d;
      j_q        <= j_d;
      i_q        <= i_d;
      done_q     <= done_d;
      if (score_we) begin
        score_q[t_q] <= mac_sum >>> SCORE_SHIFT;
      end
      // Publish the whole context only as the computation completes.
      if (state_q == StDone) begin
        for (int unsigned e = 0; e < EMBED_DIM; e++) begin
          ctx_q[e*DATA_WIDTH +: DATA_WIDTH] <= (n_q == '0) ? '0 : ctx_w[e];
        end
      end
    end
  end

  assign kv_count = kv_count_q;
  assign busy     = !idle;
  assign done     = done_q;
  assign ctx_flat = ctx_q;

endmodule

// File: tb/tb_attn_context.sv
// Directed + randomized bench for attn_context against a loop-level arithmetic model.
module tb_attn_context;

  localparam int DW   = 32;
  localparam int ED   = 64;
  localparam int SL   = 8;
  localparam int CW   = 4;
  localparam int FW   = DW * ED;
  localparam int FRAC = 14;
  localparam int SSH  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kv_wr = 1'b0;
  logic          kv_clear = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] K_flat = '0;
  logic [FW-1:0] V_flat = '0;
  logic [FW-1:0] Q_flat = '0;
  logic [CW-1:0] kv_count;
  logic          kv_full, busy, done;
  logic [FW-1:0] ctx_flat;

  int n_cmp = 0;
  int n_err = 0;

  int mk [SL][ED];
  int mv [SL][ED];
  int mcount = 0;

  always #5 clk = ~clk;

  attn_context dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kv_wr    (kv_wr),
    .kv_clear (kv_clear),
    .K_flat   (K_flat),
    .V_flat   (V_flat),
    .start    (start),
    .Q_flat   (Q_flat),
    .kv_count (kv_count),
    .kv_full  (kv_full),
    .busy     (busy),
    .done     (done),
    .ctx_flat (ctx_flat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    int e;
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      e = 0;
      while (e < ED - 1 && got[e*DW +: DW] === exp[e*DW +: DW]) e++;
      $error("FAIL %s: element %0d got %0d expected %0d", tag, e,
             $signed(got[e*DW +: DW]), $signed(exp[e*DW +: DW]));
    end
  endtask

  function automatic logic [FW-1:0] fill(input int val);
    logic [FW-1:0] r;
    for (int e = 0; e < ED; e++) r[e*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_vec(input int mode);
    logic [FW-1:0] r;
    for (int e = 0; e < ED; e++) begin
      if (mode == 0) r[e*DW +: DW] = $urandom;
      else r[e*DW +: DW] = int'($urandom_range(0, 131071)) - 65536;
    end
    return r;
  endfunction

  task automatic model_write(input logic [FW-1:0] kf, input logic [FW-1:0] vf);
    if (mcount < SL) begin
      for (int e = 0; e < ED; e++) begin
        mk[mcount][e] = kf[e*DW +: DW];
        mv[mcount][e] = vf[e*DW +: DW];
      end
      mcount++;
    end
  endtask

  // s_t = (sum_j (q_j*k_tj >>> FRAC)) >>> SSH ; ctx_i = sum_t (s_t*v_ti >>> FRAC), 32-bit wrap.
  function automatic logic [FW-1:0] model_ctx(input logic [FW-1:0] qf, input int n);
    int sc [SL];
    int s;
    logic [FW-1:0] r;
    r = '0;
    for (int t = 0; t < n; t++) begin
      s = 0;
      for (int j = 0; j < ED; j++)
        s += int'((longint'($signed(qf[j*DW +: DW])) * longint'(mk[t][j])) >>> FRAC);
      sc[t] = s >>> SSH;
    end
    for (int i = 0; i < ED; i++) begin
      s = 0;
      for (int t = 0; t < n; t++) s += int'((longint'(sc[t]) * longint'(mv[t][i])) >>> FRAC);
      r[i*DW +: DW] = s;
    end
    return r;
  endfunction

  task automatic kv_pulse(input logic wr, input logic clr, input logic [FW-1:0] kf,
                          input logic [FW-1:0] vf);
    @(negedge clk);
    kv_wr = wr;
    kv_clear = clr;
    K_flat = kf;
    V_flat = vf;
    @(negedge clk);
    kv_wr = 1'b0;
    kv_clear = 1'b0;
  endtask

  task automatic write_tok(input logic [FW-1:0] kf, input logic [FW-1:0] vf);
    kv_pulse(1'b1, 1'b0, kf, vf);
    model_write(kf, vf);
  endtask

  task automatic clear_kv();
    kv_pulse(1'b0, 1'b1, '0, '0);
    mcount = 0;
  endtask

  task automatic do_run(input string tag, input logic [FW-1:0] qf, input bit wr_with_start,
                        input bit poke);
    int n;
    int lat;
    logic [FW-1:0] exp;
    logic [FW-1:0] kf;
    logic [FW-1:0] vf;
    n = mcount;
    exp = model_ctx(qf, n);
    kf = rand_vec(1);
    vf = rand_vec(1);
    @(negedge clk);
    Q_flat = qf;
    start = 1'b1;
    if (wr_with_start) begin
      kv_wr = 1'b1;
      K_flat = kf;
      V_flat = vf;
    end
    @(negedge clk);
    start = 1'b0;
    kv_wr = 1'b0;
    if (wr_with_start) model_write(kf, vf);
    chk({tag, "_busy"}, busy, 1);
    lat = -1;
    for (int c = 1; c <= 2200; c++) begin
      if (poke && c == 3) begin
        kv_wr = 1'b1;
        K_flat = rand_vec(0);
      end
      if (poke && c == 4) begin
        kv_wr = 1'b0;
        start = 1'b1;
        kv_clear = 1'b1;
        Q_flat = ~qf;
      end
      if (poke && c == 5) begin
        start = 1'b0;
        kv_clear = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 1 + 2 * ED * n);
    chk_vec({tag, "_ctx"}, ctx_flat, exp);
    chk({tag, "_count"}, kv_count, mcount);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int seen;

    // Reset with garbage on inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      kv_wr = 1'($urandom);
      kv_clear = 1'($urandom);
      start = 1'($urandom);
      K_flat = rand_vec(0);
      V_flat = rand_vec(0);
      Q_flat = rand_vec(0);
    end
    chk("rst_count", kv_count, 0);
    chk("rst_full", kv_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_vec("rst_ctx", ctx_flat, '0);
    kv_wr = 1'b0;
    kv_clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("rst_no_done", seen, 0);

    // Single token.
    write_tok(fill(16384), fill(32768));
    do_run("single", fill(16384), 1'b0, 1'b0);
    chk_vec("single_const", ctx_flat, fill(262144));

    // Empty buffer.
    clear_kv();
    chk("clear_count", kv_count, 0);
    do_run("empty", rand_vec(0), 1'b0, 1'b0);

    // Two tokens, negative query.
    write_tok(fill(16384), fill(16384));
    write_tok(fill(16384), fill(16384));
    do_run("neg", fill(-8192), 1'b0, 1'b0);
    chk_vec("neg_const", ctx_flat, fill(-131072));

    // Fill past capacity, then clears.
    clear_kv();
    for (int w = 0; w < 9; w++) write_tok(rand_vec(1), rand_vec(1));
    chk("full_count", kv_count, 8);
    chk("full_flag", kv_full, 1);
    do_run("full8", rand_vec(1), 1'b0, 1'b0);
    clear_kv();
    chk("clr_count", kv_count, 0);
    chk("clr_full", kv_full, 0);
    write_tok(rand_vec(1), rand_vec(1));
    write_tok(rand_vec(1), rand_vec(1));
    kv_pulse(1'b1, 1'b1, rand_vec(1), rand_vec(1));
    mcount = 0;
    chk("clr_wins", kv_count, 0);

    // Start + write together, and pokes while busy.
    for (int w = 0; w < 3; w++) write_tok(rand_vec(1), rand_vec(1));
    do_run("conc", rand_vec(1), 1'b1, 1'b1);
    do_run("conc_next", rand_vec(1), 1'b0, 1'b0);

    // Full-range random values exercise wrap-around.
    clear_kv();
    for (int w = 0; w < 5; w++) write_tok(rand_vec(0), rand_vec(0));
    do_run("wrap", rand_vec(0), 1'b0, 1'b0);

    // Abort mid-score.
    clear_kv();
    write_tok(rand_vec(1), rand_vec(1));
    write_tok(rand_vec(1), rand_vec(1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_count", kv_count, 0);
    chk("abort_done", done, 0);
    chk_vec("abort_ctx", ctx_flat, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mcount = 0;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
